// File: rtl/mux_rr_scheduler_if.sv
// Request/data bus between four requesters, the round-robin scheduler and the
// downstream consumer of the captured 2-bit word.
interface mux_rr_scheduler_if;
  logic       en;
  logic [3:0] req;
  logic [7:0] data_in;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic [1:0] out_data;
  logic [1:0] out_src;
  logic       out_valid;
  logic       out_ready;
  logic       busy;

  modport master (
    output en, req, data_in, out_ready,
    input  gnt, sel, out_data, out_src, out_valid, busy
  );

  modport slave (
    input  en, req, data_in, out_ready,
    output gnt, sel, out_data, out_src, out_valid, busy
  );
endinterface

// File: rtl/mux_rr_scheduler.sv
// Round-robin scheduler for one 2-bit lane shared by four requesters, with
// per-requester burst allowance and a one-entry registered output stage.
module mux_rr_scheduler #(
  parameter int unsigned BURST = 1
) (
  input logic              clk,
  input logic              rst_n,
  mux_rr_scheduler_if.slave bus
);

  typedef enum logic [0:0] {StIdle, StFull} state_e;

  state_e     state_q;
  logic [1:0] out_data_q, out_src_q, sel_q, ptr_q, last_q;
  logic [3:0] burst_cnt_q;

  logic       any_req, hold, same_w, out_valid, cap;
  logic [1:0] idx, scan_w, win, ptr_d;
  logic [3:0] cnt_d;

  assign out_valid = (state_q == StFull);

  always_comb begin
    any_req = |bus.req;
    idx     = '0;
    scan_w  = ptr_q;
    // Descending so the requester nearest to ptr is assigned last and wins.
    for (int i = 3; i >= 0; i--) begin
      idx = ptr_q + 2'(i);
      if (bus.req[idx]) scan_w = idx;
    end
    hold = (burst_cnt_q != 4'd0) && (burst_cnt_q < 4'(BURST)) && bus.req[last_q];
    win  = hold ? last_q : scan_w;

    // rst_n gates cap so gnt reads zero for the whole reset window.
    cap = rst_n & bus.en & any_req & (~out_valid | bus.out_ready);

    same_w = (win == last_q);
    if (same_w && (burst_cnt_q < 4'(BURST))) cnt_d = burst_cnt_q + 4'd1;
    else                                     cnt_d = 4'd1;
    ptr_d = ptr_q;
    if ((cnt_d == 4'(BURST)) || !same_w) ptr_d = win + 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      out_data_q  <= 2'b00;
      out_src_q   <= 2'b00;
      sel_q       <= 2'b00;
      ptr_q       <= 2'b00;
      last_q      <= 2'b00;
      burst_cnt_q <= 4'd0;
    end else begin
      if (any_req) sel_q <= win;
      if (cap) begin
        out_data_q  <= bus.data_in[{win, 1'b0} +: 2];
        out_src_q   <= win;
        last_q      <= win;
        burst_cnt_q <= cnt_d;
        ptr_q       <= ptr_d;
      end
      unique case (state_q)
        StIdle:  if (cap) state_q <= StFull;
        StFull:  if (!cap && bus.out_ready) state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.gnt       = cap ? (4'b0001 << win) : 4'b0000;
  assign bus.sel       = (rst_n && any_req) ? win : sel_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;
  assign bus.out_valid = out_valid;
  assign bus.busy      = out_valid;

endmodule
